// File: rtl/sprite_engine_pkg.sv
// Shared definitions for the sprite engine: register offsets, default base
// address, channel FSM states and configuration helpers.
package sprite_pkg;

    // Register offsets selected by regaddress[2:1]
    localparam logic [1:0] REG_POS  = 2'd0;
    localparam logic [1:0] REG_CTL  = 2'd1;
    localparam logic [1:0] REG_DATA = 2'd2;
    localparam logic [1:0] REG_DATB = 2'd3;

    // Default register block base (byte address 0x140)
    localparam logic [8:0] SPRBASE_DEF = 9'h140;

    // Per-channel line state
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SHIFT = 2'd2
    } spr_state_e;

    // Pixel counter width: must hold the value DW itself
    function automatic int cnt_width(input int dw);
        return $clog2(dw) + 1;
    endfunction

    // Legal configuration: DW in {16,32,64}, NSPR even and in 2..8
    function automatic bit cfg_ok(input int dw, input int nspr);
        return ((dw == 16) || (dw == 32) || (dw == 64)) &&
               (nspr >= 2) && (nspr <= 8) && ((nspr % 2) == 0);
    endfunction

endpackage

// File: rtl/sprite_engine_if.sv
// Chip-bus register write port plus beam/pixel timing into the sprite engine.
interface sprite_engine_if #(
    parameter int DW = 16
);
    logic [8:1]    regaddress;
    logic [DW-1:0] datain;
    logic          wr;
    logic [8:0]    horbeam;
    logic          shift_en;

    modport master (
        output regaddress, datain, wr, horbeam, shift_en
    );

    modport slave (
        input regaddress, datain, wr, horbeam, shift_en
    );
endinterface

// File: rtl/sprite_engine_channel.sv
// One sprite channel: POS/CTL/DATA/DATB registers, line FSM, pixel counter
// and the A/B shifters producing one 2-bit pixel per shift strobe.
module sprite_channel
    import sprite_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_pos,
    input  logic          wr_ctl,
    input  logic          wr_data,
    input  logic          wr_datb,
    input  logic [DW-1:0] datain,
    input  logic [8:0]    horbeam,
    input  logic          shift_en,
    output logic [1:0]    px,
    output logic          attach
);

    localparam int            CW       = cnt_width(DW);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DW);

    spr_state_e    state_q;
    logic          armed_q;
    logic          armed_d;
    logic          attach_q;
    logic [8:0]    hstart_q;
    logic [DW-1:0] datla_q;
    logic [DW-1:0] datlb_q;
    logic [DW-1:0] shifta_q;
    logic [DW-1:0] shiftb_q;
    logic [CW-1:0] cnt_q;
    logic          match;

    // Trigger uses the registered armed/hstart, so same-cycle writes never block or move it
    always_comb begin
        match   = shift_en && armed_q && (horbeam == hstart_q);
        armed_d = armed_q;
        if (wr_ctl) begin
            armed_d = 1'b0;
        end else if (wr_data) begin
            armed_d = 1'b1;
        end
    end

    // Register file: bus writes land regardless of the pixel strobe
    always_ff @(posedge clk) begin
        if (!reset) begin
            armed_q  <= 1'b0;
            attach_q <= 1'b0;
            hstart_q <= '0;
            datla_q  <= '0;
            datlb_q  <= '0;
        end else begin
            armed_q <= armed_d;
            if (wr_pos) begin
                hstart_q[8:1] <= datain[7:0];
            end
            if (wr_ctl) begin
                attach_q    <= datain[7];
                hstart_q[0] <= datain[0];
            end
            if (wr_data) begin
                datla_q <= datain;
            end
            if (wr_datb) begin
                datlb_q <= datain;
            end
        end
    end

    // Line FSM: load on match (restarting any line in flight), shift DW pixels, then park
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            shifta_q <= '0;
            shiftb_q <= '0;
            cnt_q    <= '0;
        end else if (match) begin
            shifta_q <= datla_q;
            shiftb_q <= datlb_q;
            cnt_q    <= CNT_LOAD;
            state_q  <= ST_SHIFT;
        end else if (state_q == ST_SHIFT) begin
            if (shift_en) begin
                shifta_q <= {shifta_q[DW-2:0], 1'b0};
                shiftb_q <= {shiftb_q[DW-2:0], 1'b0};
                cnt_q    <= (cnt_q == '0) ? '0 : cnt_q - 1'b1;
                if (cnt_q <= CW'(1)) begin
                    state_q <= armed_d ? ST_ARMED : ST_IDLE;
                end
            end
        end else begin
            state_q <= armed_d ? ST_ARMED : ST_IDLE;
        end
    end

    assign px     = (state_q == ST_SHIFT) ? {shiftb_q[DW-1], shifta_q[DW-1]} : 2'b00;
    assign attach = attach_q;

endmodule

// File: rtl/sprite_engine.sv
// Sprite engine top: decodes chip-bus register writes to NSPR channels and
// resolves their pixels into a single 4-bit sprite colour index.
module sprite_engine
    import sprite_pkg::*;
#(
    parameter int         NSPR    = 8,
    parameter int         DW      = 16,
    parameter logic [8:0] SPRBASE = SPRBASE_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    sprite_engine_if.slave        bus,
    output logic [NSPR-1:0]       nsprite,
    output logic [3:0]            sprdata
);

    if (!cfg_ok(DW, NSPR)) begin : g_cfg_bad
        $error("sprite_engine: DW must be 16/32/64 and NSPR even in 2..8");
    end

    logic       base_hit;
    logic [2:0] chan;
    logic [1:0] regsel;
    logic       chan_ok;
    logic [1:0] px [NSPR];
    logic [NSPR-1:0] attach;

    // Address decode: block base match and channel index within range
    always_comb begin
        base_hit = bus.wr && (bus.regaddress[8:6] == SPRBASE[8:6]);
        chan     = bus.regaddress[5:3];
        regsel   = bus.regaddress[2:1];
        chan_ok  = ({1'b0, chan} < 4'(NSPR));
    end

    for (genvar g = 0; g < NSPR; g++) begin : g_chan
        logic sel;
        assign sel = base_hit && chan_ok && (chan == 3'(g));

        sprite_channel #(
            .DW(DW)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .wr_pos  (sel && (regsel == REG_POS)),
            .wr_ctl  (sel && (regsel == REG_CTL)),
            .wr_data (sel && (regsel == REG_DATA)),
            .wr_datb (sel && (regsel == REG_DATB)),
            .datain  (bus.datain),
            .horbeam (bus.horbeam),
            .shift_en(bus.shift_en),
            .px      (px[g]),
            .attach  (attach[g])
        );
    end

    // Per-sprite non-transparent flags
    always_comb begin
        nsprite = '0;
        for (int i = 0; i < NSPR; i++) begin
            nsprite[i] = (px[i] != 2'b00);
        end
    end

    // Priority: scan pairs high to low so the lowest active pair is the last writer
    always_comb begin
        sprdata = 4'h0;
        for (int p = NSPR / 2 - 1; p >= 0; p--) begin
            if (nsprite[2*p] || nsprite[2*p+1]) begin
                if (attach[2*p] || attach[2*p+1]) begin
                    sprdata = {px[2*p+1], px[2*p]};
                end else if (nsprite[2*p]) begin
                    sprdata = {2'(p), px[2*p]};
                end else begin
                    sprdata = {2'(p), px[2*p+1]};
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_engine.sv
// Bench for sprite_engine: drives a DW=16/NSPR=8 and a DW=64/NSPR=2 instance
// from one stimulus stream and compares both against a pixel-index model.
module tb_sprite_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [8:1]  addr;
    logic [63:0] din;
    logic        wr;
    logic        en;
    logic [8:0]  hb;
    logic [8:0]  hbv;

    sprite_engine_if #(.DW(16)) bus16 ();
    sprite_engine_if #(.DW(64)) bus64 ();

    assign bus16.regaddress = addr;
    assign bus16.datain     = din[15:0];
    assign bus16.wr         = wr;
    assign bus16.horbeam    = hb;
    assign bus16.shift_en   = en;
    assign bus64.regaddress = addr;
    assign bus64.datain     = din;
    assign bus64.wr         = wr;
    assign bus64.horbeam    = hb;
    assign bus64.shift_en   = en;

    logic [7:0] nspr16;
    logic [3:0] spr16;
    logic [1:0] nspr64;
    logic [3:0] spr64;

    sprite_engine #(.NSPR(8), .DW(16), .SPRBASE(9'h140)) dut16 (
        .clk(clk), .reset(reset), .bus(bus16), .nsprite(nspr16), .sprdata(spr16)
    );

    sprite_engine #(.NSPR(2), .DW(64), .SPRBASE(9'h140)) dut64 (
        .clk(clk), .reset(reset), .bus(bus64), .nsprite(nspr64), .sprdata(spr64)
    );

    int checks = 0;
    int failures = 0;

    // Model: each channel is "showing pixel idx of a latched line", nothing more
    typedef struct {
        logic [8:0]  hstart;
        logic        attach;
        logic        armed;
        logic        active;
        logic [63:0] la;
        logic [63:0] lb;
        logic [63:0] a;
        logic [63:0] b;
        int          idx;
    } mch_t;

    mch_t m [2][8];
    int   dwv [2] = '{16, 64};
    int   nsv [2] = '{8, 2};

    function automatic void model_edge();
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < nsv[i]; c++) begin
                mch_t o;
                mch_t n;
                logic hit;
                logic [63:0] mask;
                o = m[i][c];
                n = o;
                mask = (dwv[i] == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << dwv[i]) - 64'd1);
                if (!reset) begin
                    n = '{default: '0};
                end else begin
                    hit = en && o.armed && (hb == o.hstart);
                    if (hit) begin
                        n.active = 1'b1;
                        n.idx    = 0;
                        n.a      = o.la;
                        n.b      = o.lb;
                    end else if (en && o.active) begin
                        n.idx = o.idx + 1;
                        if (n.idx == dwv[i]) n.active = 1'b0;
                    end
                    if (wr && addr[8:6] == 3'b101 && int'(addr[5:3]) == c) begin
                        case (addr[2:1])
                            2'd0: n.hstart[8:1] = din[7:0];
                            2'd1: begin
                                n.attach    = din[7];
                                n.hstart[0] = din[0];
                                n.armed     = 1'b0;
                            end
                            2'd2: begin
                                n.la    = din & mask;
                                n.armed = 1'b1;
                            end
                            default: n.lb = din & mask;
                        endcase
                    end
                end
                m[i][c] = n;
            end
        end
    endfunction

    function automatic logic [1:0] mpx(input int i, input int c);
        int bitpos;
        if (!m[i][c].active) return 2'b00;
        bitpos = dwv[i] - 1 - m[i][c].idx;
        return {m[i][c].b[bitpos], m[i][c].a[bitpos]};
    endfunction

    task automatic expect_out(input int i, output logic [7:0] ns, output logic [3:0] sd);
        logic found;
        ns = '0;
        sd = 4'h0;
        found = 1'b0;
        for (int c = 0; c < nsv[i]; c++) ns[c] = (mpx(i, c) != 2'b00);
        for (int p = 0; p < nsv[i] / 2; p++) begin
            if (!found && (ns[2*p] || ns[2*p+1])) begin
                found = 1'b1;
                if (m[i][2*p].attach || m[i][2*p+1].attach) sd = {mpx(i, 2*p+1), mpx(i, 2*p)};
                else if (ns[2*p]) sd = {2'(p), mpx(i, 2*p)};
                else sd = {2'(p), mpx(i, 2*p+1)};
            end
        end
    endtask

    task automatic check_outputs();
        logic [7:0] e_ns;
        logic [3:0] e_sd;
        expect_out(0, e_ns, e_sd);
        checks++;
        assert (nspr16 === e_ns) else begin
            failures++;
            $error("FAIL nsprite16 t=%0t got=%h exp=%h", $time, nspr16, e_ns);
        end
        checks++;
        assert (spr16 === e_sd) else begin
            failures++;
            $error("FAIL sprdata16 t=%0t got=%h exp=%h", $time, spr16, e_sd);
        end
        expect_out(1, e_ns, e_sd);
        checks++;
        assert (nspr64 === e_ns[1:0]) else begin
            failures++;
            $error("FAIL nsprite64 t=%0t got=%h exp=%h", $time, nspr64, e_ns[1:0]);
        end
        checks++;
        assert (spr64 === e_sd) else begin
            failures++;
            $error("FAIL sprdata64 t=%0t got=%h exp=%h", $time, spr64, e_sd);
        end
    endtask

    // One clock: drive inputs, advance the model, sample after the edge
    task automatic cyc(input logic w, input logic [8:1] a, input logic [63:0] d,
                       input logic [8:0] h, input logic e);
        wr   = w;
        addr = a;
        din  = d;
        hb   = h;
        en   = e;
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    function automatic logic [8:1] ra(input int ch, input int r);
        return {3'b101, 3'(ch), 2'(r)};
    endfunction

    task automatic wreg(input int ch, input int r, input logic [63:0] d);
        cyc(1'b1, ra(ch, r), d, hbv, 1'b0);
    endtask

    // Beam sweep; mode 0: strobe every cycle, 1: every other cycle, 2: random
    task automatic run(input int n, input int mode, input int inj_k,
                       input logic [8:1] ia, input logic [63:0] id);
        for (int k = 0; k < n; k++) begin
            logic e;
            logic w;
            e = (mode == 0) ? 1'b1 : (mode == 1) ? ((k % 2) == 0) : 1'($urandom_range(0, 1));
            w = (k == inj_k);
            cyc(w, w ? ia : 8'h00, w ? id : 64'h0, hbv, e);
            if (e) hbv = hbv + 9'd1;
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        reset = 1'b0;
        hbv   = 9'h078;
        cyc(1'b0, 8'h00, 64'h0, hbv, 1'b1);
        cyc(1'b0, 8'h00, 64'h0, hbv, 1'b1);
        reset = 1'b1;
        cyc(1'b0, 8'h00, 64'h0, hbv, 1'b1);

        // Single sprite, 0x8001 pattern, hstart 0x080, then a retrigger line
        wreg(0, 0, 64'h40);
        wreg(0, 1, 64'h0);
        wreg(0, 3, 64'h0);
        wreg(0, 2, {rnd64() & 64'hFFFF_FFFF_FFFF_0000} | 64'h8001);
        hbv = 9'h078;
        run(80, 0, -1, 8'h00, 64'h0);
        hbv = 9'h078;
        run(30, 0, -1, 8'h00, 64'h0);

        // Attached pair 2/3 with all-ones data, then the same unattached
        wreg(0, 1, 64'h0);
        wreg(2, 0, 64'h40);
        wreg(3, 0, 64'h40);
        wreg(3, 1, 64'h80);
        wreg(2, 3, '1);
        wreg(3, 3, '1);
        wreg(2, 2, '1);
        wreg(3, 2, '1);
        hbv = 9'h078;
        run(30, 0, -1, 8'h00, 64'h0);
        wreg(3, 1, 64'h0);
        wreg(2, 2, '1);
        wreg(3, 2, '1);
        hbv = 9'h078;
        run(30, 0, -1, 8'h00, 64'h0);

        // Overlap of sprite 1 and sprite 4
        wreg(2, 1, 64'h0);
        wreg(3, 1, 64'h0);
        wreg(1, 0, 64'h40);
        wreg(4, 0, 64'h40);
        wreg(1, 3, rnd64());
        wreg(4, 3, '1);
        wreg(4, 2, '1);
        wreg(1, 2, '1);
        hbv = 9'h078;
        run(30, 0, -1, 8'h00, 64'h0);
        wreg(1, 1, 64'h0);
        wreg(4, 1, 64'h0);

        // Wide line with the pixel strobe toggling
        wreg(0, 3, rnd64());
        wreg(0, 2, rnd64() | 64'h8000_0000_0000_8001);
        hbv = 9'h078;
        run(170, 1, -1, 8'h00, 64'h0);

        // Disarm mid-line: line completes, next pass does not retrigger
        wreg(0, 2, rnd64());
        hbv = 9'h078;
        run(30, 0, 14, ra(0, 1), 64'h0);
        hbv = 9'h078;
        run(90, 0, -1, 8'h00, 64'h0);

        // DATA written on the match cycle: old data now, new data next line
        wreg(0, 2, 64'hF0F0_F0F0_F0F0_F0F0);
        hbv = 9'h07C;
        run(80, 0, 4, ra(0, 2), 64'h0F0F_0F0F_0F0F_0F0F);
        hbv = 9'h078;
        run(80, 0, -1, 8'h00, 64'h0);

        // Reset mid-line, then a sweep that must stay dark
        hbv = 9'h078;
        run(14, 0, -1, 8'h00, 64'h0);
        reset = 1'b0;
        cyc(1'b0, 8'h00, 64'h0, hbv, 1'b1);
        reset = 1'b1;
        hbv = 9'h078;
        run(40, 0, -1, 8'h00, 64'h0);
        hbv = 9'h000;
        run(20, 0, -1, 8'h00, 64'h0);

        // Randomised writes interleaved with random strobes
        for (int r = 0; r < 10; r++) begin
            hbv = 9'h070;
            for (int k = 0; k < 60; k++) begin
                logic e;
                e = 1'($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 3) == 0) begin
                    int ch;
                    int rg;
                    logic [63:0] d;
                    ch = $urandom_range(0, 7);
                    rg = $urandom_range(0, 3);
                    d  = rnd64();
                    if (rg == 0) d = 64'($urandom_range(8'h38, 8'h48));
                    cyc(1'b1, ra(ch, rg), d, hbv, e);
                end else begin
                    cyc(1'b0, 8'h00, 64'h0, hbv, e);
                end
                if (e) hbv = hbv + 9'd1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprite_engine.md
Name: sprite_engine

Overview:
- Parametrised successor of the OCS sprite unit in Denise: NSPR sprite channels, each DW pixels wide (16/32/64, AGA-style wide fetch), with explicit per-channel shift state, pixel counting and a pixel-rate shift strobe.
- Takes chip-bus register writes (SPRxPOS/CTL/DATA/DATB) and the horizontal beam count.
- Outputs per-sprite valid bits plus a priority-resolved 4-bit sprite colour index to the playfield/priority mixer.

Parameters:
- NSPR, 8, sprite channel count; even, 2..8.
- DW, 16, sprite line width in pixels and DATA/DATB width; legal values 16, 32, 64.
- SPRBASE, 9'h140, register base address.

Ports:
- clk  in  1  bus clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- regaddress  in  8  register address [8:1].
- datain  in  DW  bus data; POS/CTL use bits [15:0].
- wr  in  1  register write strobe, qualifies regaddress/datain.
- horbeam  in  9  horizontal beam counter.
- shift_en  in  1  pixel strobe; all shifter/FSM advances qualified by it.
- nsprite  out  NSPR  per-sprite non-transparent flags.
- sprdata  out  4  resolved sprite colour index; 0 = transparent.

Behaviour:
- Decode:
  - Channel select = wr && regaddress[8:6]==SPRBASE[8:6] && regaddress[5:3]<NSPR.
  - regaddress[2:1] selects register: 0 POS, 1 CTL, 2 DATA, 3 DATB.
  - Writes to index >= NSPR are ignored.
- Register writes (any cycle, independent of shift_en):
  - POS: hstart[8:1] <= datain[7:0].
  - CTL: attach <= datain[7]; hstart[0] <= datain[0]; armed <= 0.
  - DATA: datla <= datain; armed <= 1.
  - DATB: datlb <= datain.
- Per-channel FSM, three states:
  - IDLE (armed=0, not shifting), ARMED (armed=1, waiting), SHIFT (outputting).
  - match = shift_en && armed && horbeam==hstart. Armed is the registered value, so a CTL write in the same cycle does not block the match.
  - On match from any state: shifta <= datla, shiftb <= datlb, cnt <= DW, state <= SHIFT. A retrigger during SHIFT restarts the line.
  - SHIFT, on shift_en without match: shift both registers left by 1 with zero fill; cnt <= cnt-1. When cnt reaches 1, next state is ARMED if armed else IDLE.
  - CTL write during SHIFT disarms only; the current line completes.
  - DATA write in the same cycle as a match: the load uses the OLD datla; the new value is used from the next match.
  - cnt is $clog2(DW)+1 bits and never wraps below 0.
- Channel pixel:
  - px = {shiftb[DW-1], shifta[DW-1]} in SHIFT, else 2'b00.
  - Latency: first pixel is visible the cycle after the match edge, aligned with the playfield start.
- nsprite[i] = (px_i != 0), combinational from registers.
- Priority (combinational), lowest pair p (sprites 2p, 2p+1) with any nsprite set wins:
  - attach of either sprite in the pair -> {px_(2p+1), px_2p}.
  - Else if nsprite[2p] -> {p[1:0], px_2p}.
  - Else -> {p[1:0], px_(2p+1)}.
  - No sprite active -> 4'h0.
- Reset: all FSMs IDLE; armed, attach, hstart, datla, datlb, shifta, shiftb, cnt = 0; nsprite = 0; sprdata = 0. Reset mid-line kills output on the next edge.
- shift_en low: FSM, cnt and shifters hold; register writes still land.

Decomposition:
- Package sprite_pkg:
  - register offsets (POS/CTL/DATA/DATB);
  - default SPRBASE;
  - FSM state enum (IDLE/ARMED/SHIFT);
  - function returning the cnt width from DW;
  - elaboration check that DW is in {16,32,64} and NSPR is even and <= 8.
- Sub-module sprite_channel holds one channel's registers, FSM, counter and shifters, outputs px/attach, and is instantiated NSPR times.
- The priority resolver stays in sprite_engine.

Test Plan:
- DW=16, shift_en=1, sprite0: POS=8'h40, CTL=0, DATB=0, DATA=16'h8001 -> on horbeam 9'h080, sprdata=4'h1 the next cycle, 0 for 14 pixels, 4'h1 on the 16th, then 0. FSM returns to ARMED and retriggers at the next 9'h080.
- Sprites 2 and 3 attached (CTL bit7 on sprite 3), all-ones data, same hstart -> sprdata=4'hF for 16 pixels. Same with attach clear -> 4'h7 (pair 1, sprite 2).
- Overlap: sprite 1 and sprite 4 active on the same pixel -> sprdata={2'b00, px1}, nsprite=8'h12.
- DW=64, shift_en toggling 1/0 -> exactly 64 strobed pixels out. Output holds while shift_en=0. cnt reaches 0 with no underflow.
- CTL write mid-line -> current line completes, no retrigger on the next line. DATA write on the match cycle -> old data shown now, new data on the next line.
- Assert reset (0) mid-line -> sprdata=0 and nsprite=0 after the edge. No output until a new DATA write plus hstart match.
